// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the D-stage hazard controller.
// Slot struct widths follow HC_AW/HC_TW; hazard_ctrl's AW/TW default to these and must match them.
package hazard_ctrl_pkg;

  localparam int HC_AW         = 5;
  localparam int HC_TW         = 2;
  localparam int MULT_CYC_DFLT = 5;
  localparam int DIV_CYC_DFLT  = 10;

  localparam logic [HC_TW-1:0] TUSE_BR  = 2'd0;
  localparam logic [HC_TW-1:0] TUSE_ALU = 2'd1;
  localparam logic [HC_TW-1:0] TUSE_ST  = 2'd2;

  localparam logic [HC_TW-1:0] TNEW_ALU = 2'd1;
  localparam logic [HC_TW-1:0] TNEW_LD  = 2'd2;

  typedef struct packed {
    logic              valid;
    logic [HC_AW-1:0]  addr;
    logic [HC_TW-1:0]  tnew;
  } slot_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// D-stage request / hazard response bundle between decode (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
  parameter int AW = 5,
  parameter int TW = 2
);
  logic [AW-1:0] d_rs;
  logic [AW-1:0] d_rt;
  logic          d_rs_use;
  logic          d_rt_use;
  logic [TW-1:0] d_rs_tuse;
  logic [TW-1:0] d_rt_tuse;
  logic          d_wr_en;
  logic [AW-1:0] d_wr_addr;
  logic [TW-1:0] d_wr_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          flush;
  logic          stall;
  logic          clr_e;
  logic          md_busy;

  modport master (
    output d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
    output d_wr_en, d_wr_addr, d_wr_tnew,
    output d_md_start, d_md_div, d_md_use, flush,
    input  stall, clr_e, md_busy
  );

  modport slave (
    input  d_rs, d_rt, d_rs_use, d_rt_use, d_rs_tuse, d_rt_tuse,
    input  d_wr_en, d_wr_addr, d_wr_tnew,
    input  d_md_start, d_md_div, d_md_use, flush,
    output stall, clr_e, md_busy
  );
endinterface

// File: rtl/hazard_cmp.sv
// Single-source hazard check of one D-stage operand against one tracked pipeline slot.
module hazard_cmp
  import hazard_ctrl_pkg::*;
#(
  parameter int AW = HC_AW,
  parameter int TW = HC_TW
) (
  input  slot_t         i_slot,
  input  logic [AW-1:0] i_src,
  input  logic          i_use,
  input  logic [TW-1:0] i_tuse,
  output logic          o_hazard
);

  // r0 is hardwired zero, so it never depends on an in-flight writer.
  assign o_hazard = i_slot.valid & i_use & (i_src != '0) &
                    (i_slot.addr == i_src) & (i_slot.tnew > i_tuse);

endmodule

// File: rtl/hazard_ctrl.sv
// Tuse/Tnew stall controller tracking E and M writers; optional MDU busy model
// enabled by defining HAZARD_MDU_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int AW       = HC_AW,
  parameter int TW       = HC_TW,
  parameter int MULT_CYC = MULT_CYC_DFLT,
  parameter int DIV_CYC  = DIV_CYC_DFLT
) (
  input logic           clk,
  input logic           rst_n,
  hazard_ctrl_if.slave  hif
);

  function automatic logic [TW-1:0] sat_dec(input logic [TW-1:0] t);
    return (t == '0) ? t : t - 1'b1;
  endfunction

  logic          r_e_vld;
  logic [AW-1:0] r_e_addr;
  logic [TW-1:0] r_e_tnew;
  logic          r_m_vld;
  logic [AW-1:0] r_m_addr;
  logic [TW-1:0] r_m_tnew;

  slot_t         w_slot_e;
  slot_t         w_slot_m;
  logic [3:0]    w_haz;
  logic          w_stall;
  logic          w_md_busy;
  logic          w_md_stall;

  assign w_slot_e = '{valid: r_e_vld, addr: r_e_addr, tnew: r_e_tnew};
  assign w_slot_m = '{valid: r_m_vld, addr: r_m_addr, tnew: r_m_tnew};

  hazard_cmp #(.AW(AW), .TW(TW)) u_rs_e (
    .i_slot(w_slot_e), .i_src(hif.d_rs), .i_use(hif.d_rs_use),
    .i_tuse(hif.d_rs_tuse), .o_hazard(w_haz[0])
  );
  hazard_cmp #(.AW(AW), .TW(TW)) u_rt_e (
    .i_slot(w_slot_e), .i_src(hif.d_rt), .i_use(hif.d_rt_use),
    .i_tuse(hif.d_rt_tuse), .o_hazard(w_haz[1])
  );
  hazard_cmp #(.AW(AW), .TW(TW)) u_rs_m (
    .i_slot(w_slot_m), .i_src(hif.d_rs), .i_use(hif.d_rs_use),
    .i_tuse(hif.d_rs_tuse), .o_hazard(w_haz[2])
  );
  hazard_cmp #(.AW(AW), .TW(TW)) u_rt_m (
    .i_slot(w_slot_m), .i_src(hif.d_rt), .i_use(hif.d_rt_use),
    .i_tuse(hif.d_rt_tuse), .o_hazard(w_haz[3])
  );

  assign w_stall     = (|w_haz) | w_md_stall;
  assign hif.stall   = w_stall;
  assign hif.clr_e   = w_stall;
  assign hif.md_busy = w_md_busy;

  // Slot valid bits: flush kills both slots, a stall injects a bubble into E.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e_vld <= 1'b0;
      r_m_vld <= 1'b0;
    end else if (hif.flush) begin
      r_e_vld <= 1'b0;
      r_m_vld <= 1'b0;
    end else begin
      r_m_vld <= r_e_vld;
      r_e_vld <= ~w_stall & hif.d_wr_en & (hif.d_wr_addr != '0);
    end
  end

  // Slot payloads are qualified by the valid bits and need no reset.
  always_ff @(posedge clk) begin
    r_m_addr <= r_e_addr;
    r_m_tnew <= sat_dec(r_e_tnew);
    if (!w_stall) begin
      r_e_addr <= hif.d_wr_addr;
      r_e_tnew <= hif.d_wr_tnew;
    end
  end

`ifdef HAZARD_MDU_EN
  localparam int MAXC = (DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_md_cnt;

  // Counter keeps draining while the pipe is stalled; only an unstalled start reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_md_cnt <= '0;
    end else if (!w_stall && hif.d_md_start) begin
      r_md_cnt <= hif.d_md_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    end else if (r_md_cnt != '0) begin
      r_md_cnt <= r_md_cnt - 1'b1;
    end
  end

  assign w_md_busy  = (r_md_cnt != '0);
  assign w_md_stall = hif.d_md_use & w_md_busy;

`ifndef SYNTHESIS
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(hif.d_md_start && w_md_busy && !w_stall)
  );
`endif
`else
  logic w_unused_md;
  assign w_unused_md = ^{hif.d_md_start, hif.d_md_div, hif.d_md_use};
  assign w_md_busy   = 1'b0;
  assign w_md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl; exercises the MDU paths when HAZARD_MDU_EN is defined.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int AW     = 5;
  localparam int TW     = 2;
  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;
`ifdef HAZARD_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.AW(AW), .TW(TW)) hif ();

  hazard_ctrl #(.AW(AW), .TW(TW), .MULT_CYC(MULT_C), .DIV_CYC(DIV_C)) dut (
    .clk(clk), .rst_n(rst_n), .hif(hif)
  );

  // Reference: each issued writer is remembered with the cycle it left D.
  typedef struct { int addr; int tnew; int iss; } prod_t;
  prod_t q[$];
  int cyc = 0;
  int md_end = -1;
  int nchk = 0;
  int nfail = 0;
  bit exp_stall, exp_busy;
  bit obs_stall, obs_busy;

  function automatic bit src_haz(int s, bit use_, int tuse);
    for (int i = 0; i < q.size(); i++) begin
      int age, rem;
      age = cyc - q[i].iss;
      if (age < 1 || age > 2) continue;
      rem = q[i].tnew - (age - 1);
      if (rem < 0) rem = 0;
      if (use_ && s != 0 && s == q[i].addr && rem > tuse) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    q.delete();
    md_end = -1;
  endtask

  task automatic drive_idle();
    hif.d_rs = '0; hif.d_rt = '0; hif.d_rs_use = 0; hif.d_rt_use = 0;
    hif.d_rs_tuse = '0; hif.d_rt_tuse = '0;
    hif.d_wr_en = 0; hif.d_wr_addr = '0; hif.d_wr_tnew = '0;
    hif.d_md_start = 0; hif.d_md_div = 0; hif.d_md_use = 0; hif.flush = 0;
  endtask

  task automatic drive_wr(int a, int t);
    drive_idle();
    hif.d_wr_en = 1; hif.d_wr_addr = AW'(a); hif.d_wr_tnew = TW'(t);
  endtask

  task automatic drive_rd(int s, int tuse);
    drive_idle();
    hif.d_rs = AW'(s); hif.d_rs_use = 1; hif.d_rs_tuse = TW'(tuse);
  endtask

  // One clock: predict, compare at negedge, advance the model at posedge.
  task automatic step(input string tag);
    exp_busy  = MDU && (cyc <= md_end);
    exp_stall = src_haz(int'(hif.d_rs), hif.d_rs_use, int'(hif.d_rs_tuse)) |
                src_haz(int'(hif.d_rt), hif.d_rt_use, int'(hif.d_rt_tuse)) |
                (hif.d_md_use & exp_busy);
    @(negedge clk);
    obs_stall = hif.stall;
    obs_busy  = hif.md_busy;
    nchk++;
    if (hif.stall !== exp_stall) begin
      nfail++;
      $display("FAIL %s stall cyc=%0d got=%b exp=%b", tag, cyc, hif.stall, exp_stall);
    end
    nchk++;
    if (hif.clr_e !== exp_stall) begin
      nfail++;
      $display("FAIL %s clr_e cyc=%0d got=%b exp=%b", tag, cyc, hif.clr_e, exp_stall);
    end
    nchk++;
    if (hif.md_busy !== exp_busy) begin
      nfail++;
      $display("FAIL %s md_busy cyc=%0d got=%b exp=%b", tag, cyc, hif.md_busy, exp_busy);
    end
    @(posedge clk);
    if (!exp_stall && MDU && hif.d_md_start)
      md_end = cyc + (hif.d_md_div ? DIV_C : MULT_C);
    if (hif.flush) q.delete();
    else if (!exp_stall && hif.d_wr_en)
      q.push_back('{int'(hif.d_wr_addr), int'(hif.d_wr_tnew), cyc});
    cyc++;
    while (q.size() > 0 && cyc - q[0].iss > 2) void'(q.pop_front());
    #1;
  endtask

  task automatic check_in_reset(input string tag);
    #1;
    nchk++;
    if (hif.stall !== 1'b0 || hif.clr_e !== 1'b0 || hif.md_busy !== 1'b0) begin
      nfail++;
      $display("FAIL %s outputs in reset got stall=%b clr_e=%b md_busy=%b exp 0 0 0",
               tag, hif.stall, hif.clr_e, hif.md_busy);
    end
  endtask

  task automatic test_reset();
    drive_rd(8, 0);
    hif.d_md_use = 1;
    check_in_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    drive_idle();
    step("post_reset");
  endtask

  task automatic test_load_use();
    int n = 0;
    drive_wr(8, TNEW_LD);
    step("ld_issue");
    drive_rd(8, TUSE_BR);
    for (int i = 0; i < 8; i++) begin
      step("ld_use");
      if (obs_stall) n++;
      else break;
    end
    nchk++;
    if (n !== 2) begin
      nfail++;
      $display("FAIL ld_use_count got=%0d exp=2", n);
    end
    drive_idle(); step("ld_idle");
  endtask

  task automatic test_alu_fwd();
    int n = 0;
    drive_wr(9, TNEW_ALU);
    step("alu_issue");
    drive_rd(9, TUSE_ALU);
    hif.d_rt = AW'(9); hif.d_rt_use = 1; hif.d_rt_tuse = TUSE_ALU;
    for (int i = 0; i < 3; i++) begin
      step("alu_use");
      if (obs_stall) n++;
    end
    nchk++;
    if (n !== 0) begin
      nfail++;
      $display("FAIL alu_fwd_count got=%0d exp=0", n);
    end
    drive_idle(); step("alu_idle");
  endtask

  task automatic test_r0_and_nouse();
    int n = 0;
    drive_wr(0, TNEW_LD);
    step("r0_issue");
    drive_rd(0, TUSE_BR);
    step("r0_use"); if (obs_stall) n++;
    drive_wr(12, TNEW_LD);
    step("nouse_issue");
    drive_rd(12, TUSE_BR);
    hif.d_rs_use = 0;
    step("nouse_1"); if (obs_stall) n++;
    step("nouse_2"); if (obs_stall) n++;
    nchk++;
    if (n !== 0) begin
      nfail++;
      $display("FAIL r0_nouse_count got=%0d exp=0", n);
    end
    drive_idle(); step("r0_idle");
  endtask

  task automatic test_flush();
    bit s1, s2;
    drive_wr(8, TNEW_LD);
    step("fl_issue");
    drive_rd(8, TUSE_BR);
    hif.flush = 1;
    step("fl_edge"); s1 = obs_stall;
    hif.flush = 0;
    step("fl_after"); s2 = obs_stall;
    nchk++;
    if (s1 !== 1'b1 || s2 !== 1'b0) begin
      nfail++;
      $display("FAIL flush_seq got=%b%b exp=10", s1, s2);
    end
    drive_idle(); step("fl_idle");
  endtask

  task automatic test_reset_mid_stall();
    drive_wr(8, TNEW_LD);
    step("rms_issue");
    drive_rd(8, TUSE_BR);
    step("rms_stall");
    rst_n = 1'b0;
    check_in_reset("rms_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    step("rms_after");
    nchk++;
    if (obs_stall !== 1'b0) begin
      nfail++;
      $display("FAIL rms_after_stall got=%b exp=0", obs_stall);
    end
    drive_idle(); step("rms_idle");
  endtask

  task automatic test_mdu_op(input bit div, input int cyc_exp, input string tag);
    int ns = 0, nb = 0;
    drive_idle();
    hif.d_md_start = 1; hif.d_md_div = div; hif.d_md_use = 1;
    step(tag);
    drive_idle();
    hif.d_md_use = 1;
    for (int i = 0; i < DIV_C + 4; i++) begin
      step(tag);
      if (obs_stall) ns++;
      if (obs_busy) nb++;
      if (!obs_stall) break;
    end
    nchk++;
    if (ns !== cyc_exp || nb !== cyc_exp) begin
      nfail++;
      $display("FAIL %s_count stall=%0d busy=%0d exp=%0d", tag, ns, nb, cyc_exp);
    end
    drive_idle(); step(tag);
  endtask

  task automatic test_mdu_reset();
    drive_idle();
    hif.d_md_start = 1; hif.d_md_div = 1; hif.d_md_use = 1;
    step("mdr_start");
    drive_idle();
    hif.d_md_use = 1;
    repeat (3) step("mdr_wait");
    rst_n = 1'b0;
    check_in_reset("mdr_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_clear();
    step("mdr_after");
    nchk++;
    if (obs_stall !== 1'b0 || obs_busy !== 1'b0) begin
      nfail++;
      $display("FAIL mdr_after got stall=%b busy=%b exp 0 0", obs_stall, obs_busy);
    end
    drive_idle(); step("mdr_idle");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      hif.d_rs      = AW'($urandom_range(0, 3));
      hif.d_rt      = AW'($urandom_range(0, 3));
      hif.d_rs_use  = 1'($urandom_range(0, 1));
      hif.d_rt_use  = 1'($urandom_range(0, 1));
      hif.d_rs_tuse = TW'($urandom_range(0, 3));
      hif.d_rt_tuse = TW'($urandom_range(0, 3));
      hif.d_wr_en   = 1'($urandom_range(0, 1));
      hif.d_wr_addr = AW'($urandom_range(0, 3));
      hif.d_wr_tnew = TW'($urandom_range(0, 3));
      hif.d_md_start = ($urandom_range(0, 11) == 0);
      hif.d_md_div   = 1'($urandom_range(0, 1));
      hif.d_md_use   = hif.d_md_start | ($urandom_range(0, 3) == 0);
      hif.flush      = ($urandom_range(0, 19) == 0);
      step("random");
    end
    drive_idle(); step("rand_idle");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout nchk=%0d", nchk);
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_r0_and_nouse();
    test_flush();
    test_reset_mid_stall();
`ifdef HAZARD_MDU_EN
    test_mdu_op(1'b1, DIV_C, "div");
    test_mdu_op(1'b0, MULT_C, "mult");
    test_mdu_reset();
`else
    test_mdu_op(1'b1, 0, "mdu_off");
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: AW, 5, register address width.
REQ-002 Parameter: TW, 2, width of the Tuse/Tnew fields.
REQ-003 Parameter: MULT_CYC, 5, MDU busy cycles for multiply.
REQ-004 Parameter: DIV_CYC, 10, MDU busy cycles for divide.
REQ-005 The block SHALL have exactly one clock; reset is asynchronous and active-low. Ports: clk  in  1  clock; rst_n  in  1  async active-low reset.
REQ-006 Ports: d_rs, d_rt  in  AW  D-stage source addresses; d_rs_use, d_rt_use  in  1  source is read; d_rs_tuse, d_rt_tuse  in  TW  cycles until the value is needed.
REQ-007 Ports: d_wr_en  in  1  D instr writes a GPR; d_wr_addr  in  AW  destination; d_wr_tnew  in  TW  Tnew on entering E (ALU 1, load 2).
REQ-008 Ports: d_md_start  in  1  mult/div; d_md_div  in  1  divide; d_md_use  in  1  reads/writes HI/LO or starts the MDU.
REQ-009 Ports: flush  in  1  synchronous clear of tracked E/M entries.
REQ-010 Ports: stall  out  1  freeze PC and F/D; clr_e  out  1  bubble into E; md_busy  out  1  MDU busy.

Function
REQ-011 SHALL keep two tracked slots, E and M, each holding {valid, addr, tnew}.
REQ-012 On each clk edge when stall=0: E <= {d_wr_en & (d_wr_addr!=0), d_wr_addr, d_wr_tnew}.
REQ-013 On each clk edge when stall=1: E <= invalid (bubble).
REQ-014 On every clk edge: M <= E with tnew decremented, saturating at 0. Slot W is not tracked.
REQ-015 Per source s with s_use=1 and s!=0: hazard_E = E.valid & E.addr==s & E.tnew>s_tuse.
REQ-016 Per source s with s_use=1 and s!=0: hazard_M = M.valid & M.addr==s & (M.tnew)>s_tuse.
REQ-017 stall SHALL be the OR of all hazards plus the MDU stall; it is combinational with zero latency. clr_e == stall.
REQ-018 Address 0 SHALL never cause a stall. A source with use=0 SHALL never cause a stall.
REQ-019 flush=1 SHALL invalidate E and M on the edge, overriding REQ-012/013. MDU state is unaffected.

Reset
REQ-020 rst_n=0 SHALL asynchronously clear E.valid, M.valid, and the MDU counter. Outputs while in reset: stall=0, clr_e=0, md_busy=0.
REQ-021 Reset asserted mid-stall or mid-MDU operation SHALL abandon all state. The first cycle after release behaves as if empty.

Configuration
REQ-022 Macro HAZARD_MDU_EN, when defined, enables the MDU model:
- On an edge with stall=0 and d_md_start=1, counter <= d_md_div ? DIV_CYC : MULT_CYC.
- Otherwise the counter decrements toward 0 every cycle, including during stalls.
- md_busy = (counter!=0).
- MDU stall = d_md_use & md_busy.
REQ-023 Without HAZARD_MDU_EN: no counter is built, md_busy is tied to 0, and the d_md_* inputs are ignored.
REQ-024 A start while busy cannot occur, because d_md_start implies d_md_use and therefore stalls. The implementation SHALL assert against it in simulation.

Structure
REQ-025 A shared package SHALL hold:
- the tracked-slot struct {valid, addr, tnew};
- Tuse constants TUSE_BR=0, TUSE_ALU=1, TUSE_ST=2;
- Tnew constants TNEW_ALU=1, TNEW_LD=2;
- MULT_CYC and DIV_CYC defaults.
REQ-026 One sub-module, hazard_cmp, SHALL compute a single-source hazard against one slot. It SHALL be instantiated 4 times (rs/rt × E/M).

Verification
REQ-027 Load r8 (tnew 2), then next cycle beq on r8 (tuse 0): stall=1 for 2 cycles, then stall=0.
REQ-028 addu r9 (tnew 1), then next cycle addu reading r9 (tuse 1): stall=0 throughout.
REQ-029 Load r0, then dependent instruction reads r0 with tuse 0: stall=0.
REQ-030 Load r8, with flush=1 on the next edge while beq r8 waits in D: stall drops to 0 after the flush edge.
REQ-031 With HAZARD_MDU_EN: div issued, then mflo follows: md_busy=1 for 10 cycles and stall=1 for those cycles.
REQ-032 With HAZARD_MDU_EN: mult issued, then mflo follows: stall=1 for 5 cycles.
REQ-033 rst_n pulsed low mid-division: md_busy=0 immediately, and stall=0 after release.
